// File: rtl/vp_checkpoint_sequencer.sv
// vp_checkpoint_sequencer
//
// Runs one speculative load past a D-cache miss using load value prediction.
// On an accepted miss it forwards the predicted value, checkpoints the
// register file, and keeps replaying the missed request until the fill
// returns. The fill is then compared with the prediction. A wrong prediction
// restores the checkpoint, flushes the pipeline and refetches from the load.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   miss_valid/pc/addr        D-cache miss of the load in MEM (used in IDLE only)
//   lookup_pc                 predictor lookup PC (combinational copy of miss_pc)
//   pred_valid/pred_data      predictor answer for lookup_pc, same cycle
//   use_pred                  select pred_data as the MEM load result
//   snapshot_take             one-cycle pulse: checkpoint the register file
//   replay_valid/replay_addr  held request driven back to the D-cache
//   fill_valid/fill_data      D-cache data for the held request
//   spec_mem_op               load/store decoded while speculating
//   pipe_stall, pipe_flush    pipeline control
//   restore                   one-cycle pulse: restore the register snapshot
//   load_pc_we/load_pc        fetch PC redirect
//   train_valid/pc/data       predictor update
//   spec_correct/spec_wrong   saturating outcome counters
//   state_dbg                 current FSM state, for observation only
//
// Handshake: there is no backpressure. miss_valid, fill_valid and spec_mem_op
// are single-cycle qualifiers sampled on the rising clock edge. Every output
// is valid in the cycle in which it is asserted.

module vp_checkpoint_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid,
    input  logic [DATA_WIDTH-1:0] miss_pc,
    input  logic [DATA_WIDTH-1:0] miss_addr,
    output logic [DATA_WIDTH-1:0] lookup_pc,
    input  logic                  pred_valid,
    input  logic [DATA_WIDTH-1:0] pred_data,
    output logic                  use_pred,
    output logic                  snapshot_take,
    output logic                  replay_valid,
    output logic [DATA_WIDTH-1:0] replay_addr,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  spec_mem_op,
    output logic                  pipe_stall,
    output logic                  pipe_flush,
    output logic                  restore,
    output logic                  load_pc_we,
    output logic [DATA_WIDTH-1:0] load_pc,
    output logic                  train_valid,
    output logic [DATA_WIDTH-1:0] train_pc,
    output logic [DATA_WIDTH-1:0] train_data,
    output logic [CNT_WIDTH-1:0]  spec_correct,
    output logic [CNT_WIDTH-1:0]  spec_wrong,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SPEC     = 3'd1,
        HOLD     = 3'd2,
        RECOVER  = 3'd3,
        REDIRECT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] spec_pc_q, spec_addr_q, spec_pred_q;
    logic                  spec_active_q;
    logic                  snap_pend_q;
    logic [CNT_WIDTH-1:0]  correct_q, wrong_q;

    logic accept;
    logic inc_correct;
    logic inc_wrong;

    assign lookup_pc    = miss_pc;
    assign spec_correct = correct_q;
    assign spec_wrong   = wrong_q;
    assign state_dbg    = state_q;

    // Next state and outputs. While rst is high every output stays at its
    // default so that an abandoned recovery issues no further pulses.
    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        inc_correct   = 1'b0;
        inc_wrong     = 1'b0;
        use_pred      = 1'b0;
        snapshot_take = 1'b0;
        replay_valid  = 1'b0;
        replay_addr   = '0;
        pipe_stall    = 1'b0;
        pipe_flush    = 1'b0;
        restore       = 1'b0;
        load_pc_we    = 1'b0;
        load_pc       = '0;
        train_valid   = 1'b0;
        train_pc      = '0;
        train_data    = '0;

        if (rst) begin
            state_d = IDLE;
        end else begin
            // The checkpoint pulse belongs to the first SPEC cycle.
            snapshot_take = snap_pend_q;
            unique case (state_q)
                IDLE: begin
                    if (miss_valid) begin
                        accept   = 1'b1;
                        use_pred = pred_valid;
                        state_d  = pred_valid ? SPEC : HOLD;
                    end
                end
                SPEC, HOLD: begin
                    replay_valid = 1'b1;
                    replay_addr  = spec_addr_q;
                    if (fill_valid) begin
                        // The fill wins over a colliding spec_mem_op, so no stall here.
                        train_valid = 1'b1;
                        train_pc    = spec_pc_q;
                        train_data  = fill_data;
                        if (!spec_active_q) begin
                            state_d = IDLE;
                        end else if (fill_data == spec_pred_q) begin
                            inc_correct = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            inc_wrong = 1'b1;
                            state_d   = RECOVER;
                        end
                    end else if (state_q == HOLD || spec_mem_op) begin
                        // A second memory op cannot run under an unresolved
                        // speculation, so the pipeline waits for the fill.
                        pipe_stall = 1'b1;
                        state_d    = HOLD;
                    end
                end
                RECOVER: begin
                    restore    = 1'b1;
                    pipe_flush = 1'b1;
                    state_d    = REDIRECT;
                end
                REDIRECT: begin
                    load_pc_we = 1'b1;
                    load_pc    = spec_pc_q;
                    pipe_flush = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            spec_pc_q     <= '0;
            spec_addr_q   <= '0;
            spec_pred_q   <= '0;
            spec_active_q <= 1'b0;
            snap_pend_q   <= 1'b0;
            correct_q     <= '0;
            wrong_q       <= '0;
        end else begin
            state_q     <= state_d;
            snap_pend_q <= accept && pred_valid;
            if (accept) begin
                spec_pc_q     <= miss_pc;
                spec_addr_q   <= miss_addr;
                spec_pred_q   <= pred_data;
                spec_active_q <= pred_valid;
            end
            if (inc_correct && (correct_q != {CNT_WIDTH{1'b1}})) begin
                correct_q <= correct_q + 1'b1;
            end
            if (inc_wrong && (wrong_q != {CNT_WIDTH{1'b1}})) begin
                wrong_q <= wrong_q + 1'b1;
            end
        end
    end

endmodule
